mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-port signals around the fetch/data memory arbiter.
// The slave modport is the arbiter's view; master is the view of requesters plus memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  inst_req_valid;
    logic                  inst_req_ready;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  inst_resp_valid;
    logic [31:0]           inst_rdata;

    logic                  data_req_valid;
    logic                  data_req_ready;
    logic                  data_wen;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [31:0]           data_wdata;
    logic                  data_resp_valid;
    logic [31:0]           data_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  inst_req_valid, inst_addr, data_req_valid, data_wen, data_addr, data_wdata,
               mem_rdata,
        output inst_req_ready, inst_resp_valid, inst_rdata, data_req_ready, data_resp_valid,
               data_rdata, mem_addr, mem_ren, mem_wen, mem_wdata
    );

    modport master (
        output inst_req_valid, inst_addr, data_req_valid, data_wen, data_addr, data_wdata,
               mem_rdata,
        input  inst_req_ready, inst_resp_valid, inst_rdata, data_req_ready, data_resp_valid,
               data_rdata, mem_addr, mem_ren, mem_wen, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ideal single-port memory between a fetch and a data requester.
// Each transaction is accept (IDLE) -> memory access (ACCESS) -> one-cycle response (RESP).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                state_q;
    logic                  last_data_q;
    logic                  req_data_q;
    logic                  req_store_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  mem_ren_q;
    logic                  mem_wen_q;
    logic                  inst_resp_q;
    logic                  data_resp_q;
    logic [31:0]           inst_rdata_q;
    logic [31:0]           data_rdata_q;

    logic grant_inst;
    logic grant_data;
    logic grant_store;

    // On a tie, whoever was not granted last wins.
    always_comb begin
        grant_inst  = !rst && (state_q == StIdle) && bus.inst_req_valid &&
                      (!bus.data_req_valid || last_data_q);
        grant_data  = !rst && (state_q == StIdle) && bus.data_req_valid && !grant_inst;
        grant_store = grant_data && bus.data_wen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_data_q  <= 1'b1;
            req_data_q   <= 1'b0;
            req_store_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            inst_resp_q  <= 1'b0;
            data_resp_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_inst || grant_data) begin
                        state_q     <= StAccess;
                        last_data_q <= grant_data;
                        req_data_q  <= grant_data;
                        req_store_q <= grant_store;
                        mem_addr_q  <= grant_data ? bus.data_addr : bus.inst_addr;
                        mem_wdata_q <= grant_store ? bus.data_wdata : '0;
                        mem_ren_q   <= !grant_store;
                        mem_wen_q   <= grant_store;
                    end
                end
                StAccess: begin
                    state_q     <= StResp;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_ren_q   <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    if (req_data_q) begin
                        data_resp_q  <= 1'b1;
                        data_rdata_q <= req_store_q ? '0 : bus.mem_rdata;
                    end else begin
                        inst_resp_q  <= 1'b1;
                        inst_rdata_q <= bus.mem_rdata;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    inst_resp_q <= 1'b0;
                    data_resp_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gating by rst keeps a store caught mid-ACCESS from writing and zeroes outputs in reset.
    always_comb begin
        bus.inst_req_ready  = grant_inst;
        bus.data_req_ready  = grant_data;
        bus.inst_resp_valid = !rst && inst_resp_q;
        bus.data_resp_valid = !rst && data_resp_q;
        bus.inst_rdata      = rst ? '0 : inst_rdata_q;
        bus.data_rdata      = rst ? '0 : data_rdata_q;
        bus.mem_addr        = rst ? '0 : mem_addr_q;
        bus.mem_wdata       = rst ? '0 : mem_wdata_q;
        bus.mem_ren         = !rst && mem_ren_q;
        bus.mem_wen         = !rst && mem_wen_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table for arbitration/memory timing, scoreboard for
// responses, plus hand sequences for tie alternation, reset mid-store and a request dropped in RESP.
module tb_mem_arbiter;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus();

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'h2401_0065;
        if (i == 211) return 32'd5;
        return 32'(i) ^ 32'hA5A5_0000;
    endfunction

    // Ideal memory: asynchronous read, synchronous write.
    logic [31:0] mem [0:1023];
    bit mem_loaded = 1'b0;
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        bit          is_data;
        bit          is_store;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          acc_cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [0:1023];
    bit          ref_loaded = 1'b0;
    bit          cur_is_data = 1'b0;

    // Scoreboard monitor: push on acceptance, pop on response, two cycles apart.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!ref_loaded) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
            ref_loaded = 1'b1;
        end
        if (rst) begin
            check("rst_outputs_zero", 64'(|{bus.inst_req_ready, bus.inst_resp_valid,
                  bus.inst_rdata, bus.data_req_ready, bus.data_resp_valid, bus.data_rdata,
                  bus.mem_addr, bus.mem_ren, bus.mem_wen, bus.mem_wdata}), 64'd0);
            sbq.delete();
        end else begin
            if (bus.inst_resp_valid) begin
                ok = (sbq.size() != 0) && !sbq[0].is_data;
                check("inst_resp_expected", 64'(ok), 64'd1);
                if (ok) begin
                    e = sbq.pop_front();
                    check("inst_rdata", 64'(bus.inst_rdata), 64'(e.rdata));
                    check("inst_latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
            if (bus.data_resp_valid) begin
                ok = (sbq.size() != 0) && sbq[0].is_data;
                check("data_resp_expected", 64'(ok), 64'd1);
                if (ok) begin
                    e = sbq.pop_front();
                    check("data_rdata", 64'(bus.data_rdata), 64'(e.rdata));
                    check("data_latency", 64'(cyc - e.acc_cyc), 64'd2);
                    if (e.is_store) ref_mem[e.addr] = e.wdata;
                end
            end
            if (bus.inst_req_valid && bus.inst_req_ready) begin
                e = '{1'b0, 1'b0, bus.inst_addr, 32'd0, ref_mem[bus.inst_addr], cyc};
                sbq.push_back(e);
                cur_is_data = 1'b0;
            end
            if (bus.data_req_valid && bus.data_req_ready) begin
                e = '{1'b1, bus.data_wen, bus.data_addr, bus.data_wdata,
                      bus.data_wen ? 32'd0 : ref_mem[bus.data_addr], cyc};
                sbq.push_back(e);
                cur_is_data = 1'b1;
            end
            if (bus.mem_wen) check("fetch_never_writes", 64'(cur_is_data), 64'd1);
        end
    end

    typedef struct {
        logic        iv;
        logic        dv;
        logic        dwen;
        logic [9:0]  iaddr;
        logic [9:0]  daddr;
        logic [31:0] wdata;
        logic        exp_ir;
        logic        exp_dr;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic dv, input logic dwen, input logic [9:0] ia,
                         input logic [9:0] da, input logic [31:0] wd);
        bus.inst_req_valid = iv;
        bus.data_req_valid = dv;
        bus.data_wen       = dwen;
        bus.inst_addr      = ia;
        bus.data_addr      = da;
        bus.data_wdata     = wd;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_acc;
        logic exp_store;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 10'd3,   10'd0,   32'd0,         1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 10'd0,   10'd210, 32'd1,         1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 10'd0,   10'd210, 32'd0,         1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 10'd5,   10'd210, 32'd0,         1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 10'd5,   10'd210, 32'd0,         1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 10'd6,   10'd400, 32'd77,        1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 10'd9,   10'd401, 32'd78,        1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 10'd8,   10'd300, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 10'd0,   10'd300, 32'd0,         1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 10'd300, 10'd300, 32'hFFFF_FFFF, 1'b1, 1'b0};

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_inst_rdata", 64'(bus.inst_rdata), 64'd0);
        check("reset_data_rdata", 64'(bus.data_rdata), 64'd0);
        check("reset_mem_ren", 64'(bus.mem_ren), 64'd0);

        // Each vector: accept (N), access with scrambled inputs (N+1), response (N+2).
        for (int i = 0; i < 10; i++) begin
            step();
            drive(vecs[i].iv, vecs[i].dv, vecs[i].dwen, vecs[i].iaddr, vecs[i].daddr,
                  vecs[i].wdata);
            @(negedge clk);
            check($sformatf("v%0d_inst_ready", i), 64'(bus.inst_req_ready), 64'(vecs[i].exp_ir));
            check($sformatf("v%0d_data_ready", i), 64'(bus.data_req_ready), 64'(vecs[i].exp_dr));
            step();
            drive(1'b0, 1'b0, ~vecs[i].dwen, ~vecs[i].iaddr, vecs[i].daddr ^ 10'h155,
                  ~vecs[i].wdata);
            exp_acc   = vecs[i].exp_ir | vecs[i].exp_dr;
            exp_store = vecs[i].exp_dr & vecs[i].dwen;
            @(negedge clk);
            check($sformatf("v%0d_mem_ren", i), 64'(bus.mem_ren), 64'(exp_acc & !exp_store));
            check($sformatf("v%0d_mem_wen", i), 64'(bus.mem_wen), 64'(exp_store));
            check($sformatf("v%0d_mem_addr", i), 64'(bus.mem_addr),
                  64'(!exp_acc ? 10'd0 : (vecs[i].exp_dr ? vecs[i].daddr : vecs[i].iaddr)));
            check($sformatf("v%0d_mem_wdata", i), 64'(bus.mem_wdata),
                  64'(exp_store ? vecs[i].wdata : 32'd0));
            step();
            @(negedge clk);
            check($sformatf("v%0d_resp_idle_mem", i), 64'({bus.mem_ren, bus.mem_wen}), 64'd0);
        end

        // Request raised only during RESP must be ignored.
        step();
        drive(1'b1, 1'b0, 1'b0, 10'd7, '0, '0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        drive(1'b0, 1'b1, 1'b1, '0, 10'd500, 32'd123);
        @(negedge clk);
        check("resp_valid_no_ready", 64'(bus.data_req_ready), 64'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("dropped_no_access", 64'({bus.mem_ren, bus.mem_wen}), 64'd0);
            step();
        end
        check("dropped_mem_untouched", 64'(mem[500]), 64'(init_word(500)));

        // Reset during ACCESS of a store: no write, no response, back in IDLE.
        drive(1'b0, 1'b1, 1'b1, '0, 10'd211, 32'd99);
        @(negedge clk);
        check("store211_ready", 64'(bus.data_req_ready), 64'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_store_blocked", 64'(mem[211]), 64'd5);
        check("rst_cleared_data_rdata", 64'(bus.data_rdata), 64'd0);
        check("rst_cleared_inst_rdata", 64'(bus.inst_rdata), 64'd0);
        step();
        drive(1'b0, 1'b1, 1'b0, '0, 10'd211, '0);
        @(negedge clk);
        check("idle_after_rst", 64'(bus.data_req_ready), 64'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step();

        // Both valid from reset: fetch first, then strict alternation every three cycles.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 10'd21, 10'd20, '0);
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("tie_inst_ready_%0d", k), 64'(bus.inst_req_ready),
                  64'(k % 6 == 0));
            check($sformatf("tie_data_ready_%0d", k), 64'(bus.data_req_ready),
                  64'(k % 6 == 3));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) step();
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
